// File: rtl/uart_led_pwm_ctrl.sv
// UART-commanded LED controller: 8N1 receiver, two-byte command parser,
// per-LED PWM levels on a shared counter, and an 8N1 reply transmitter.
module uart_led_pwm_ctrl #(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_LEDS     = 7,
  parameter int PWM_BITS     = 4,
  parameter int PWM_PRESCALE = 64,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i,
  output logic                o,
  output logic [NUM_LEDS-1:0] led_port,
  output logic                frame_err,
  output logic                tx_drop
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int ALL_N = (NUM_LEDS < 8) ? NUM_LEDS : 8;

  localparam logic [7:0]          CH_K      = 8'h4B;
  localparam logic [7:0]          CH_E      = 8'h45;
  localparam logic [2:0]          OP_SET    = 3'd0;
  localparam logic [2:0]          OP_BRIGHT = 3'd1;
  localparam logic [2:0]          OP_ALL    = 3'd2;
  localparam logic [2:0]          OP_READ   = 3'd3;
  localparam logic [PWM_BITS-1:0] FULL      = '1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
  typedef enum logic [1:0] {P_IDLE, P_WAIT, P_EXEC} p_state_e;

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_e        r_rx_state, w_rx_next;
  logic [BIT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_valid, r_frame_err;
  logic             w_rx_fall, w_rx_tick, w_rx_half;

  // Synchronizer flops reset low so a line already low at reset release
  // cannot masquerade as a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b0;
      r_rx_sync <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_meta <= i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_tick = (r_rx_cnt == BIT_W'(CLKS_PER_BIT - 1));
  assign w_rx_half = (r_rx_cnt == BIT_W'(CLKS_PER_BIT / 2 - 1));

  // NOTE: every signal driven here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (w_rx_tick && r_rx_sync) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // NOTE: clocked state is written with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
      r_frame_err <= (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync;
      // In BREAK the counter measures one uninterrupted high bit time.
      if (w_rx_next != r_rx_state)                     r_rx_cnt <= '0;
      else if (r_rx_state == RX_DATA && w_rx_tick)     r_rx_cnt <= '0;
      else if (r_rx_state == RX_BREAK && !r_rx_sync)   r_rx_cnt <= '0;
      else if (r_rx_state != RX_IDLE)                  r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state != RX_DATA) begin
        r_rx_bit <= '0;
      end else if (w_rx_tick) begin
        r_rx_bit   <= r_rx_bit + 1'b1;
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
      end
    end
  end

  p_state_e            r_p_state, w_p_next;
  logic [2:0]          r_op;
  logic [4:0]          r_idx;
  logic [TO_W-1:0]     r_to_cnt;
  logic                w_timeout, w_idx_ok;
  logic [PWM_BITS-1:0] w_rd_level;
  logic [7:0]          w_exec_reply;
  logic                w_reply_valid;
  logic [7:0]          w_reply_byte;
  logic [PWM_BITS-1:0] r_level [NUM_LEDS];

  assign w_timeout = (r_p_state == P_WAIT) && (r_rx_state == RX_IDLE) && !w_rx_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1));

  always_comb begin
    w_p_next = r_p_state;
    case (r_p_state)
      P_IDLE:  if (!r_frame_err && r_rx_valid) w_p_next = P_WAIT;
      P_WAIT:  if (r_frame_err || w_timeout) w_p_next = P_IDLE;
               else if (r_rx_valid)          w_p_next = P_EXEC;
      default: w_p_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_p_state <= P_IDLE;
    else     r_p_state <= w_p_next;
  end

  // Byte 2 stays in the RX shift register through EXEC, so only byte 1 is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_idx    <= '0;
      r_to_cnt <= '0;
    end else begin
      if (r_p_state == P_IDLE && r_rx_valid) {r_op, r_idx} <= r_rx_shift;
      if (r_p_state != P_WAIT || r_rx_state != RX_IDLE) r_to_cnt <= '0;
      else                                              r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    w_idx_ok   = 1'b0;
    w_rd_level = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (r_idx == 5'(k)) begin
        w_idx_ok   = 1'b1;
        w_rd_level = r_level[k];
      end
    end
    w_exec_reply = CH_E;
    case (r_op)
      OP_SET, OP_BRIGHT: if (w_idx_ok) w_exec_reply = CH_K;
      OP_ALL:            w_exec_reply = CH_K;
      OP_READ:           if (w_idx_ok) w_exec_reply = 8'(w_rd_level);
      default:           w_exec_reply = CH_E;
    endcase
  end

  assign w_reply_valid = (r_p_state == P_EXEC) || r_frame_err || w_timeout;
  assign w_reply_byte  = (r_p_state == P_EXEC) ? w_exec_reply : CH_E;

  // NOTE: the level array is a handful of flops, so it is reset like any register; a RAM-style array would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_LEDS; k++) r_level[k] <= '0;
    end else if (r_p_state == P_EXEC) begin
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (r_idx == 5'(k)) begin
          if (r_op == OP_SET)         r_level[k] <= r_rx_shift[0] ? FULL : '0;
          else if (r_op == OP_BRIGHT) r_level[k] <= r_rx_shift[PWM_BITS-1:0];
        end
      end
      if (r_op == OP_ALL) begin
        for (int k = 0; k < ALL_N; k++) r_level[k] <= r_rx_shift[k] ? FULL : '0;
      end
    end
  end

  logic [PRE_W-1:0]    r_pwm_pre;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [NUM_LEDS-1:0] r_led;

  // Counter stops one short of full scale so full scale is on every step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_pre <= '0;
      r_pwm_cnt <= '0;
      r_led     <= '0;
    end else begin
      if (r_pwm_pre == PRE_W'(PWM_PRESCALE - 1)) begin
        r_pwm_pre <= '0;
        r_pwm_cnt <= (r_pwm_cnt == PWM_BITS'(2**PWM_BITS - 2)) ? '0 : r_pwm_cnt + 1'b1;
      end else begin
        r_pwm_pre <= r_pwm_pre + 1'b1;
      end
      for (int k = 0; k < NUM_LEDS; k++) r_led[k] <= (r_level[k] > r_pwm_cnt);
    end
  end

  logic             r_tx_busy, r_tx_o, r_pend_valid, r_tx_drop;
  logic [8:0]       r_tx_shift;
  logic [BIT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [7:0]       r_pend_byte;
  logic             w_tx_done, w_load;
  logic [7:0]       w_load_byte;

  assign w_tx_done = r_tx_busy && (r_tx_cnt == BIT_W'(CLKS_PER_BIT - 1)) && (r_tx_bit == 4'd9);

  always_comb begin
    w_load      = 1'b0;
    w_load_byte = w_reply_byte;
    if (!r_tx_busy) begin
      w_load = w_reply_valid;
    end else if (w_tx_done) begin
      w_load = r_pend_valid | w_reply_valid;
      if (r_pend_valid) w_load_byte = r_pend_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy    <= 1'b0;
      r_tx_o       <= 1'b1;
      r_tx_shift   <= '1;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_byte  <= '0;
      r_tx_drop    <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_busy  <= 1'b1;
        r_tx_o     <= 1'b0;
        r_tx_shift <= {1'b1, w_load_byte};
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
      end else if (r_tx_busy) begin
        if (r_tx_cnt == BIT_W'(CLKS_PER_BIT - 1)) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 4'd9) begin
            r_tx_busy <= 1'b0;
          end else begin
            r_tx_o     <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            r_tx_bit   <= r_tx_bit + 1'b1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
      // Pending slot drains into the shifter at end of frame; a third reply is lost.
      if (w_tx_done && r_pend_valid) begin
        r_pend_valid <= w_reply_valid;
        r_pend_byte  <= w_reply_byte;
      end else if (r_tx_busy && !w_tx_done && w_reply_valid) begin
        if (!r_pend_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_byte  <= w_reply_byte;
        end else begin
          r_tx_drop <= 1'b1;
        end
      end
    end
  end

  assign o         = r_tx_o;
  assign led_port  = r_led;
  assign frame_err = r_frame_err;
  assign tx_drop   = r_tx_drop;

endmodule
